board_ctrl: RTL and testbench
=============================

Name: board_ctrl

Overview:
- Game-state controller for the 3x3 tic-tac-toe board.
- Turns mouse clicks into square ownership, alternates turns between the two colours, and detects a win or a draw.
- Sits directly upstream of the per-square draw stages and drives each stage's square, square colour, start_en and choice_en inputs.
- Screen is 1024x768. Colour encoding is 0 = blue, 1 = yellow.

Parameters:
- COL1_END, 338, last hcount/xpos of column 0
- COL2_END, 676, last xpos of column 1
- H_MAX, 1023, last valid xpos
- ROW1_END, 251, last ypos of row 0
- ROW2_END, 502, last ypos of row 1
- V_MAX, 767, last valid ypos

Ports:
- pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the pclk edge)
- start_en  in  1  game running; low clears the board and returns to IDLE
- choice_en  in  1  menu/choice screen active; pauses play
- first_color  in  1  colour that moves first, sampled on IDLE->PLAY
- xpos  in  12  mouse x, pclk domain
- ypos  in  12  mouse y, pclk domain
- mouse_left  in  1  left button level, pclk domain
- square  out  9  occupied flag per square; index = row*3+col; bit0 = top-left
- square_color  out  9  owner colour per square; valid only where square=1
- current_color  out  1  colour to move next
- game_over  out  1  high in OVER
- draw  out  1  high in OVER when there is no winner
- winner_color  out  1  winning colour; valid when game_over && !draw

Behaviour:
- All outputs are registered.
- Reset (rst==0) clears every output to 0, sets state to IDLE and sets the click history register to 0.
- Click edge: click = mouse_left && !mouse_left_q, where mouse_left_q is a one-cycle-delayed register.
- Square mapping, column:
  - col = 0 if xpos<=COL1_END
  - col = 1 if xpos<=COL2_END
  - col = 2 if xpos<=H_MAX
  - otherwise the click is invalid
- Row mapping uses ypos against ROW1_END, ROW2_END and V_MAX in the same way.
- IDLE:
  - board is cleared and game_over, draw and winner_color are 0
  - when start_en && !choice_en: load current_color = first_color and go to PLAY
- PLAY:
  - choice_en=1: hold state, ignore clicks, keep the board
  - valid click on a free square at cycle N: at N+1, square[i]=1, square_color[i]=current_color, state=CHECK
  - click on an occupied square or outside the screen: no change
- CHECK (exactly one cycle) evaluates 8 lines (3 rows, 3 columns, 2 diagonals) using the board registers:
  - any line fully occupied with equal colours: at N+2, game_over=1, draw=0, winner_color = that colour, state=OVER
  - else all 9 squares occupied: game_over=1, draw=1, state=OVER
  - else: toggle current_color, state=PLAY
  - clicks arriving during CHECK are dropped, not queued
- OVER:
  - board and result are held
  - clicks are ignored
  - current_color is frozen
- start_en=0 in any state: next cycle goes to IDLE and the board is cleared. This has priority over clicks and CHECK.
- rst has priority over everything, including mid-CHECK.
- A simultaneous win and full board reports a win (draw=0).
- A held button produces exactly one click. A new move requires a release and a re-press.

Test Plan:
- Reset then start: rst=0 for 3 cycles, then rst=1, start_en=1, choice_en=0, first_color=0.
  - Required: all outputs 0, then PLAY with current_color=0.
- Single move: click at (100,100).
  - Required: square=9'h001 one cycle after the edge sample; square_color[0]=0; two cycles after, current_color=1.
  - Holding the button for 50 cycles changes nothing further.
- Occupied and out-of-range clicks: click (100,100) again, then click (1100,100).
  - Required: square and current_color unchanged.
- Row win: blue moves to squares 0,1,2 (clicks at x=100, 400, 800; y=100), with yellow moves to squares 3 and 4 in between.
  - Required: two cycles after the third blue click, game_over=1, draw=0, winner_color=0.
  - A further click changes nothing.
- Draw: move sequence 0,1,2,4,3,5,7,6,8 starting with blue.
  - Required: square=9'h1FF, game_over=1, draw=1.
- Pause and abort:
  - choice_en=1 during PLAY plus a click on a free square: no change.
  - start_en=0 mid-game: the next cycle gives square=0, game_over=0, state IDLE.
  - rst=0 asserted in the same cycle as a valid click: board stays 0.

Source files
------------

// File: rtl/board_ctrl_if.sv
// Bundle of game-control inputs and board/result outputs between the menu/mouse
// logic and board_ctrl.
//   master : drives start_en, choice_en, first_color, xpos, ypos, mouse_left;
//            observes the board and result outputs
//   slave  : board_ctrl side (inverse directions)
interface board_ctrl_if;
    logic        start_en;
    logic        choice_en;
    logic        first_color;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic [8:0]  square;
    logic [8:0]  square_color;
    logic        current_color;
    logic        game_over;
    logic        draw;
    logic        winner_color;

    modport master (
        output start_en, choice_en, first_color, xpos, ypos, mouse_left,
        input  square, square_color, current_color, game_over, draw, winner_color
    );

    modport slave (
        input  start_en, choice_en, first_color, xpos, ypos, mouse_left,
        output square, square_color, current_color, game_over, draw, winner_color
    );
endinterface

// File: rtl/board_ctrl.sv
// Tic-tac-toe game-state controller. Maps left-click edges to board squares,
// alternates turns between blue (0) and yellow (1), and detects win or draw.
// Ports:
//   pclk : pixel clock
//   rst  : synchronous active-low reset
//   bus  : board_ctrl_if.slave (control inputs, mouse, board/result outputs)
module board_ctrl #(
    parameter logic [11:0] COL1_END = 12'd338,
    parameter logic [11:0] COL2_END = 12'd676,
    parameter logic [11:0] H_MAX    = 12'd1023,
    parameter logic [11:0] ROW1_END = 12'd251,
    parameter logic [11:0] ROW2_END = 12'd502,
    parameter logic [11:0] V_MAX    = 12'd767
) (
    input  logic         pclk,
    input  logic         rst,
    board_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StPlay, StCheck, StOver} state_e;

    state_e     state_q, state_d;
    logic       mouse_left_q;
    logic [8:0] square_q, square_d;
    logic [8:0] color_q, color_d;
    logic       cur_q, cur_d;
    logic       over_q, over_d;
    logic       draw_q, draw_d;
    logic       win_col_q, win_col_d;

    logic       click;
    logic [1:0] col, row;
    logic       col_ok, row_ok;
    logic [3:0] idx;
    logic [8:0] sel;
    logic       win_any, win_color;

    assign click = bus.mouse_left && !mouse_left_q;

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b1;
        if (bus.xpos <= COL1_END)      col = 2'd0;
        else if (bus.xpos <= COL2_END) col = 2'd1;
        else if (bus.xpos <= H_MAX)    col = 2'd2;
        else                           col_ok = 1'b0;

        row    = 2'd0;
        row_ok = 1'b1;
        if (bus.ypos <= ROW1_END)      row = 2'd0;
        else if (bus.ypos <= ROW2_END) row = 2'd1;
        else if (bus.ypos <= V_MAX)    row = 2'd2;
        else                           row_ok = 1'b0;
    end

    assign idx = {2'b00, row} * 4'd3 + {2'b00, col};
    assign sel = 9'd1 << idx;

    function automatic logic line_full(input logic [8:0] sq, input logic [8:0] c,
                                       input int a, input int b, input int d);
        return sq[a] && sq[b] && sq[d] && (c[a] == c[b]) && (c[b] == c[d]);
    endfunction

    // First matching line decides the colour; two winning colours cannot coexist.
    always_comb begin
        win_any   = 1'b0;
        win_color = 1'b0;
        if (line_full(square_q, color_q, 0, 1, 2)) begin win_any = 1'b1; win_color = color_q[0]; end
        else if (line_full(square_q, color_q, 3, 4, 5)) begin win_any = 1'b1; win_color = color_q[3]; end
        else if (line_full(square_q, color_q, 6, 7, 8)) begin win_any = 1'b1; win_color = color_q[6]; end
        else if (line_full(square_q, color_q, 0, 3, 6)) begin win_any = 1'b1; win_color = color_q[0]; end
        else if (line_full(square_q, color_q, 1, 4, 7)) begin win_any = 1'b1; win_color = color_q[1]; end
        else if (line_full(square_q, color_q, 2, 5, 8)) begin win_any = 1'b1; win_color = color_q[2]; end
        else if (line_full(square_q, color_q, 0, 4, 8)) begin win_any = 1'b1; win_color = color_q[0]; end
        else if (line_full(square_q, color_q, 2, 4, 6)) begin win_any = 1'b1; win_color = color_q[2]; end
    end

    always_comb begin
        state_d   = state_q;
        square_d  = square_q;
        color_d   = color_q;
        cur_d     = cur_q;
        over_d    = over_q;
        draw_d    = draw_q;
        win_col_d = win_col_q;

        if (!bus.start_en) begin
            state_d   = StIdle;
            square_d  = 9'd0;
            color_d   = 9'd0;
            over_d    = 1'b0;
            draw_d    = 1'b0;
            win_col_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    square_d  = 9'd0;
                    color_d   = 9'd0;
                    over_d    = 1'b0;
                    draw_d    = 1'b0;
                    win_col_d = 1'b0;
                    if (!bus.choice_en) begin
                        cur_d   = bus.first_color;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (!bus.choice_en && click && col_ok && row_ok && ((square_q & sel) == 9'd0)) begin
                        square_d = square_q | sel;
                        color_d  = cur_q ? (color_q | sel) : (color_q & ~sel);
                        state_d  = StCheck;
                    end
                end
                StCheck: begin
                    if (win_any) begin
                        over_d    = 1'b1;
                        draw_d    = 1'b0;
                        win_col_d = win_color;
                        state_d   = StOver;
                    end else if (&square_q) begin
                        over_d  = 1'b1;
                        draw_d  = 1'b1;
                        state_d = StOver;
                    end else begin
                        cur_d   = ~cur_q;
                        state_d = StPlay;
                    end
                end
                StOver: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q      <= StIdle;
            mouse_left_q <= 1'b0;
            square_q     <= 9'd0;
            color_q      <= 9'd0;
            cur_q        <= 1'b0;
            over_q       <= 1'b0;
            draw_q       <= 1'b0;
            win_col_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mouse_left_q <= bus.mouse_left;
            square_q     <= square_d;
            color_q      <= color_d;
            cur_q        <= cur_d;
            over_q       <= over_d;
            draw_q       <= draw_d;
            win_col_q    <= win_col_d;
        end
    end

    assign bus.square        = square_q;
    assign bus.square_color  = color_q;
    assign bus.current_color = cur_q;
    assign bus.game_over     = over_q;
    assign bus.draw          = draw_q;
    assign bus.winner_color  = win_col_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: reset, moves, invalid clicks, win, draw,
// pause, abort and reset-during-click.
module tb_board_ctrl;
    logic pclk = 1'b0;
    logic rst;

    board_ctrl_if bus ();

    board_ctrl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    int xs[3] = '{100, 400, 800};
    int ys[3] = '{100, 300, 600};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic press(input int x, input int y);
        bus.xpos       = 12'(x);
        bus.ypos       = 12'(y);
        bus.mouse_left = 1'b1;
        tick();
    endtask

    task automatic release_btn();
        bus.mouse_left = 1'b0;
        tick();
    endtask

    // Full click on square i: press, release, one idle cycle.
    task automatic move_sq(input int i);
        press(xs[i % 3], ys[i / 3]);
        release_btn();
        tick();
    endtask

    task automatic restart(input logic fc);
        bus.start_en = 1'b0;
        tick();
        bus.first_color = fc;
        bus.start_en    = 1'b1;
        tick();
    endtask

    initial begin
        rst             = 1'b0;
        bus.start_en    = 1'b0;
        bus.choice_en   = 1'b0;
        bus.first_color = 1'b0;
        bus.xpos        = 12'd0;
        bus.ypos        = 12'd0;
        bus.mouse_left  = 1'b0;
        repeat (3) tick();
        check("rst_square", bus.square, 9'h000);
        check("rst_sqcol", bus.square_color, 9'h000);
        check("rst_cur", bus.current_color, 1'b0);
        check("rst_over", bus.game_over, 1'b0);
        check("rst_draw", bus.draw, 1'b0);
        check("rst_winner", bus.winner_color, 1'b0);

        rst          = 1'b1;
        bus.start_en = 1'b1;
        tick();
        check("start_cur", bus.current_color, 1'b0);

        // Single move, then hold the button.
        press(100, 100);
        check("mv_square", bus.square, 9'h001);
        check("mv_sqcol", bus.square_color, 9'h000);
        tick();
        check("mv_cur", bus.current_color, 1'b1);
        repeat (49) tick();
        check("hold_square", bus.square, 9'h001);
        check("hold_cur", bus.current_color, 1'b1);
        release_btn();
        tick();

        // Occupied and off-screen clicks.
        move_sq(0);
        check("occ_square", bus.square, 9'h001);
        check("occ_cur", bus.current_color, 1'b1);
        press(1100, 100); release_btn(); tick();
        check("oobx_square", bus.square, 9'h001);
        press(100, 800); release_btn(); tick();
        check("ooby_square", bus.square, 9'h001);
        check("oob_cur", bus.current_color, 1'b1);

        // Abort mid-game.
        bus.start_en = 1'b0;
        tick();
        check("abort_square", bus.square, 9'h000);
        check("abort_over", bus.game_over, 1'b0);

        // Blue row win on 0,1,2 with yellow on 3,4.
        bus.first_color = 1'b0;
        bus.start_en    = 1'b1;
        tick();
        move_sq(0); move_sq(3); move_sq(1); move_sq(4);
        press(800, 100);
        check("row_over_n1", bus.game_over, 1'b0);
        release_btn();
        check("row_over", bus.game_over, 1'b1);
        check("row_draw", bus.draw, 1'b0);
        check("row_winner", bus.winner_color, 1'b0);
        check("row_square", bus.square, 9'h01F);
        check("row_sqcol", bus.square_color, 9'h018);
        tick();
        move_sq(8);
        check("over_square", bus.square, 9'h01F);
        check("over_hold", bus.game_over, 1'b1);
        check("over_cur", bus.current_color, 1'b0);

        // Yellow moves first and wins column 0.
        restart(1'b1);
        check("y_start_cur", bus.current_color, 1'b1);
        move_sq(0); move_sq(1); move_sq(3); move_sq(4); move_sq(6);
        check("col_over", bus.game_over, 1'b1);
        check("col_draw", bus.draw, 1'b0);
        check("col_winner", bus.winner_color, 1'b1);
        check("col_sqcol", bus.square_color, 9'h049);

        // Draw.
        restart(1'b0);
        move_sq(0); move_sq(1); move_sq(2); move_sq(4);
        move_sq(3); move_sq(5); move_sq(7); move_sq(6);
        check("pre_draw_over", bus.game_over, 1'b0);
        move_sq(8);
        check("draw_square", bus.square, 9'h1FF);
        check("draw_sqcol", bus.square_color, 9'h072);
        check("draw_over", bus.game_over, 1'b1);
        check("draw_flag", bus.draw, 1'b1);

        // Pause blocks clicks.
        restart(1'b0);
        move_sq(0);
        bus.choice_en = 1'b1;
        move_sq(4);
        check("pause_square", bus.square, 9'h001);
        check("pause_cur", bus.current_color, 1'b1);
        bus.choice_en = 1'b0;
        tick();
        move_sq(4);
        check("resume_square", bus.square, 9'h011);
        check("resume_sqcol", bus.square_color, 9'h010);

        // Reset asserted together with a valid click.
        restart(1'b0);
        rst = 1'b0;
        press(400, 100);
        check("rstclk_square", bus.square, 9'h000);
        rst = 1'b1;
        tick();
        release_btn();
        tick();
        check("rstclk_square2", bus.square, 9'h000);
        move_sq(2);
        check("after_rst_square", bus.square, 9'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
